// File: rtl/piso.sv
// Parallel-in serial-out shift register: loads a WIDTH-bit word, shifts it out MSB first.
// shift_in fills the vacated LSB on every shift, so stages can be chained.
module piso #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             shift_in,
   output logic             serial_out
);

   logic [WIDTH-1:0] shift_reg;

   // Reset beats load, load beats shift; shifting is the default every other cycle.
   always_ff @(posedge clk) begin
      if (rst)
         shift_reg <= '0;
      else if (load)
         shift_reg <= parallel_in;
      else
         shift_reg <= {shift_reg[WIDTH-2:0], shift_in};
   end

   assign serial_out = shift_reg[WIDTH-1];

endmodule

// File: tb/tb_piso.sv
// Scoreboard bench for piso: each scenario queues expected serial_out/register values
// before driving a clock edge, then pops and compares once the edge has settled.
module tb_piso;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] parallel_in = '0;
   logic         shift_in = 1'b0;
   logic         serial_out;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic         r;
      logic         l;
      logic [W-1:0] p;
      logic         s;
      logic         so;
      logic [W-1:0] q;
   } stim_t;

   typedef struct {
      logic         so;
      logic [W-1:0] q;
   } exp_t;

   exp_t exp_q[$];

   piso #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .parallel_in(parallel_in),
      .shift_in   (shift_in),
      .serial_out (serial_out)
   );

   always #5 clk = ~clk;

   // Apply inputs, take one rising edge, settle 1 time unit past it.
   task automatic drive(input logic r, input logic l, input logic [W-1:0] p, input logic s);
      rst = r; load = l; parallel_in = p; shift_in = s;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t t [2];
      exp_t  e;
      t = '{'{1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000},
            '{1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000}};
      foreach (t[i]) begin
         exp_q.push_back('{t[i].so, t[i].q});
         drive(t[i].r, t[i].l, t[i].p, t[i].s);
         e = exp_q.pop_front();
         checks++;
         if (serial_out !== e.so || dut.shift_reg !== e.q) begin
            failures++;
            $display("FAIL reset step%0d: serial_out=%b reg=%b, want serial_out=%b reg=%b",
                     i, serial_out, dut.shift_reg, e.so, e.q);
         end
      end
   endtask

   task automatic test_load_shift();
      stim_t t [5];
      exp_t  e;
      t = '{'{1'b0, 1'b1, 4'b1011, 1'b0, 1'b1, 4'b1011},
            '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0110},
            '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1100},
            '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000},
            '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000}};
      foreach (t[i]) begin
         exp_q.push_back('{t[i].so, t[i].q});
         drive(t[i].r, t[i].l, t[i].p, t[i].s);
         e = exp_q.pop_front();
         checks++;
         if (serial_out !== e.so || dut.shift_reg !== e.q) begin
            failures++;
            $display("FAIL load_shift step%0d: serial_out=%b reg=%b, want serial_out=%b reg=%b",
                     i, serial_out, dut.shift_reg, e.so, e.q);
         end
      end
   endtask

   task automatic test_serial_fill();
      stim_t t [5];
      exp_t  e;
      t = '{'{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000},
            '{1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001},
            '{1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0011},
            '{1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0111},
            '{1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111}};
      foreach (t[i]) begin
         exp_q.push_back('{t[i].so, t[i].q});
         drive(t[i].r, t[i].l, t[i].p, t[i].s);
         e = exp_q.pop_front();
         checks++;
         if (serial_out !== e.so || dut.shift_reg !== e.q) begin
            failures++;
            $display("FAIL serial_fill step%0d: serial_out=%b reg=%b, want serial_out=%b reg=%b",
                     i, serial_out, dut.shift_reg, e.so, e.q);
         end
      end
   endtask

   task automatic test_load_priority();
      stim_t t [6];
      exp_t  e;
      t = '{'{1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000},
            '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000},
            '{1'b0, 1'b1, 4'b0111, 1'b1, 1'b0, 4'b0111},
            '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1110},
            '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1100},
            '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000}};
      foreach (t[i]) begin
         exp_q.push_back('{t[i].so, t[i].q});
         drive(t[i].r, t[i].l, t[i].p, t[i].s);
         e = exp_q.pop_front();
         checks++;
         if (serial_out !== e.so || dut.shift_reg !== e.q) begin
            failures++;
            $display("FAIL load_priority step%0d: serial_out=%b reg=%b, want serial_out=%b reg=%b",
                     i, serial_out, dut.shift_reg, e.so, e.q);
         end
      end
   endtask

   task automatic test_held_load();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{1'b1, 4'b1010});
         drive(1'b0, 1'b1, 4'b1010, 1'b1);
         e = exp_q.pop_front();
         checks++;
         if (serial_out !== e.so || dut.shift_reg !== e.q) begin
            failures++;
            $display("FAIL held_load step%0d: serial_out=%b reg=%b, want serial_out=%b reg=%b",
                     i, serial_out, dut.shift_reg, e.so, e.q);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t t [5];
      exp_t  e;
      t = '{'{1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b1111},
            '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1110},
            '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1100},
            '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000},
            '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001}};
      foreach (t[i]) begin
         exp_q.push_back('{t[i].so, t[i].q});
         drive(t[i].r, t[i].l, t[i].p, t[i].s);
         e = exp_q.pop_front();
         checks++;
         if (serial_out !== e.so || dut.shift_reg !== e.q) begin
            failures++;
            $display("FAIL reset_mid step%0d: serial_out=%b reg=%b, want serial_out=%b reg=%b",
                     i, serial_out, dut.shift_reg, e.so, e.q);
         end
      end
   endtask

   // Random traffic against a behavioural reference; starts from a known cleared state.
   task automatic test_random();
      logic [W-1:0] m;
      logic         r, l, s;
      logic [W-1:0] p;
      exp_t         e;
      drive(1'b1, 1'b0, 4'b0000, 1'b0);
      m = '0;
      for (int i = 0; i < 80; i++) begin
         r = ($urandom_range(0, 15) == 0);
         l = ($urandom_range(0, 3) == 0);
         s = 1'($urandom_range(0, 1));
         p = W'($urandom_range(0, 15));
         if (r)      m = '0;
         else if (l) m = p;
         else        m = {m[W-2:0], s};
         exp_q.push_back('{m[W-1], m});
         drive(r, l, p, s);
         e = exp_q.pop_front();
         checks++;
         if (serial_out !== e.so || dut.shift_reg !== e.q) begin
            failures++;
            $display("FAIL random cyc%0d: serial_out=%b reg=%b, want serial_out=%b reg=%b",
                     i, serial_out, dut.shift_reg, e.so, e.q);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_shift();
      test_serial_fill();
      test_load_priority();
      test_held_load();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
